// File: rtl/prog_rom_loader_pkg.sv
// Shared types and constants for the program ROM loader and its memory.
package prog_rom_loader_pkg;

    localparam int unsigned PROG_DEPTH = 32;

    // CPU fetch address: bank select plus 4-bit offset, giving a 5-bit memory index.
    typedef struct packed {
        logic       mode;
        logic [3:0] addr;
    } addr_t;

    // Instruction byte as seen by the CPU.
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] imm;
    } data_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StRun   = 2'd2,
        StError = 2'd3
    } loader_state_t;

    // Additive checksum step; wraps modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_rom_loader_if.sv
// Fetch and load-stream signals between the loader and its host/CPU.
interface prog_rom_loader_if;
    import prog_rom_loader_pkg::*;

    addr_t       fetch_addr;
    data_t       fetch_data;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        load_done;
    logic        load_error;

    // Host / CPU side.
    modport master (
        output fetch_addr,
        output load_start,
        output load_valid,
        output load_byte,
        input  fetch_data,
        input  load_ready,
        input  load_done,
        input  load_error
    );

    // Loader side.
    modport slave (
        input  fetch_addr,
        input  load_start,
        input  load_valid,
        input  load_byte,
        output fetch_data,
        output load_ready,
        output load_done,
        output load_error
    );

endinterface

// File: rtl/prog_rom_loader_mem.sv
// DEPTH x 8 program store: async-clear register array, one sync write port,
// one combinational read port.
module prog_rom_loader_mem
    import prog_rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH = PROG_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  data_t         wdata,
    input  logic [AW-1:0] raddr,
    output data_t         rdata
);

    data_t mem_q [DEPTH];

    // Reset wipes every byte so no partial image survives a reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Zero-latency read: the CPU samples data on the edge that advances its address.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_rom_loader.sv
// Program memory stage for the 4-bit CPU: serves fetches, accepts a checksummed
// program over a valid/ready byte stream, and holds the CPU in reset until a
// verified image is present.
module prog_rom_loader
    import prog_rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH    = PROG_DEPTH,
    parameter int unsigned TIMEOUT  = 1024,
    parameter bit          AUTO_RUN = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    prog_rom_loader_if.slave    bus,
    output logic                cpu_run,
    output logic [1:0]          state_o
);

    localparam int unsigned AW = $bits(addr_t);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam loader_state_t RESET_STATE = AUTO_RUN ? StRun : StIdle;
    // Index of the checksum byte, which follows the DEPTH program bytes.
    localparam logic [CW-1:0] CSUM_IDX    = CW'(DEPTH);
    localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT - 1);

    loader_state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    sum_q,   sum_d;
    logic [TW-1:0] tout_q,  tout_d;
    logic          done_q,  done_d;

    logic          accept;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    // A start pulse pre-empts any byte offered in the same cycle.
    assign bus.load_ready = (state_q == StLoad) && !bus.load_start;
    assign accept         = bus.load_valid && bus.load_ready;

    assign mem_we    = accept && (count_q < CSUM_IDX);
    assign mem_waddr = count_q[AW-1:0];

    prog_rom_loader_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (data_t'(bus.load_byte)),
        .raddr (AW'(bus.fetch_addr)),
        .rdata (bus.fetch_data)
    );

    // State, counters and the done pulse register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            count_q <= '0;
            sum_q   <= '0;
            tout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            tout_q  <= tout_d;
            done_q  <= done_d;
        end
    end

    // Next-state: start (re)enters LOAD from anywhere; LOAD consumes bytes,
    // checks the trailing checksum and watches for a stalled host.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        tout_d  = tout_q;
        done_d  = 1'b0;

        if (bus.load_start) begin
            state_d = StLoad;
            count_d = '0;
            sum_d   = '0;
            tout_d  = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        // Acceptance clears the stall counter even on its last cycle.
                        tout_d = '0;
                        if (count_q == CSUM_IDX) begin
                            if (bus.load_byte == sum_q) begin
                                state_d = StRun;
                                done_d  = 1'b1;
                            end else begin
                                state_d = StError;
                            end
                        end else begin
                            count_d = count_q + CW'(1);
                            sum_d   = csum_add(sum_q, bus.load_byte);
                        end
                    end else if (tout_q == TOUT_LAST) begin
                        state_d = StError;
                    end else begin
                        tout_d = tout_q + TW'(1);
                    end
                end
                StIdle, StRun, StError: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode the state register only, so cpu_run cannot glitch.
    assign cpu_run        = (state_q == StRun);
    assign bus.load_error = (state_q == StError);
    assign bus.load_done  = done_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_prog_rom_loader.sv
// Scoreboard bench for prog_rom_loader: stimulus pushes expected probes and
// events into queues; a negedge monitor pops and compares them.
module tb_prog_rom_loader;
    import prog_rom_loader_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_run;
    logic [1:0] state_o;

    always #5 clock = ~clock;

    prog_rom_loader_if bus ();

    prog_rom_loader #(
        .DEPTH    (32),
        .TIMEOUT  (8),
        .AUTO_RUN (1'b0)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .cpu_run (cpu_run),
        .state_o (state_o)
    );

    typedef struct {
        string      name;
        logic [4:0] addr;
        logic [7:0] data;
        logic [1:0] state;
        logic       run;
        logic       err;
        logic       rdy;
    } probe_t;

    typedef enum {EvDone, EvError} ev_t;

    probe_t probe_q[$];
    ev_t    ev_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    logic   done_prev   = 1'b0;
    logic   err_prev    = 1'b0;

    // Monitor: compares queued snapshots and load_done / load_error events.
    always @(negedge clock) begin
        probe_t     p;
        ev_t        e;
        logic [7:0] fd;
        fd = bus.fetch_data;
        if (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            vectors++;
            if (fd !== p.data || state_o !== p.state || cpu_run !== p.run ||
                bus.load_error !== p.err || bus.load_ready !== p.rdy) begin
                miscompares++;
                $display("FAIL %s @%h: got data=%h state=%0d run=%b err=%b rdy=%b, want data=%h state=%0d run=%b err=%b rdy=%b",
                         p.name, p.addr, fd, state_o, cpu_run, bus.load_error, bus.load_ready,
                         p.data, p.state, p.run, p.err, p.rdy);
            end
        end
        if (bus.load_done === 1'b1) begin
            vectors++;
            if (done_prev) begin
                miscompares++;
                $display("FAIL done_width: load_done high for 2+ cycles, want 1-cycle pulse");
            end else if (ev_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: load_done=1 with no expected event");
            end else begin
                e = ev_q.pop_front();
                if (e != EvDone || cpu_run !== 1'b1 || state_o !== 2'd2) begin
                    miscompares++;
                    $display("FAIL done_event: got ev=done run=%b state=%0d, want ev=%s run=1 state=2",
                             cpu_run, state_o, e.name());
                end
            end
        end
        if (bus.load_error === 1'b1 && !err_prev) begin
            vectors++;
            if (ev_q.size() == 0) begin
                miscompares++;
                $display("FAIL error_unexpected: load_error rose with no expected event");
            end else begin
                e = ev_q.pop_front();
                if (e != EvError || cpu_run !== 1'b0 || state_o !== 2'd3) begin
                    miscompares++;
                    $display("FAIL error_event: got ev=error run=%b state=%0d, want ev=%s run=0 state=3",
                             cpu_run, state_o, e.name());
                end
            end
        end
        done_prev <= bus.load_done;
        err_prev  <= bus.load_error;
    end

    task automatic probe(input string name, input logic [4:0] a, input logic [7:0] d,
                         input logic [1:0] st, input logic rdy);
        probe_t p;
        bus.fetch_addr = addr_t'(a);
        p.name  = name;
        p.addr  = a;
        p.data  = d;
        p.state = st;
        p.run   = (st == 2'd2);
        p.err   = (st == 2'd3);
        p.rdy   = rdy;
        probe_q.push_back(p);
        @(negedge clock);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start();
        bus.load_start = 1'b1;
        tick(1);
        bus.load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        tick(1);
        bus.load_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_byte  = 8'h00;
        #1 reset = 1'b1;

        // Reset state: IDLE, CPU held, memory all zero.
        for (int i = 0; i < 32; i++) probe("reset_mem", 5'(i), 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        tick(1);
        probe("idle_after_reset", 5'h1A, 8'h00, 2'd0, 1'b0);

        // Normal load of 0x00..0x1F; checksum 496 mod 256 = 0xF0.
        start();
        probe("load_entered", 5'h00, 8'h00, 2'd1, 1'b1);
        for (int i = 0; i < 32; i++) send(8'(i));
        ev_q.push_back(EvDone);
        send(8'hF0);
        probe("run_fetch_1A", 5'h1A, 8'h1A, 2'd2, 1'b0);
        probe("run_fetch_1F", 5'h1F, 8'h1F, 2'd2, 1'b0);
        probe("run_fetch_00", 5'h00, 8'h00, 2'd2, 1'b0);

        // Restart from RUN drops cpu_run; bad checksum 0xF1 goes to ERROR.
        start();
        probe("run_drops", 5'h03, 8'h03, 2'd1, 1'b1);
        for (int i = 0; i < 32; i++) send(8'(i));
        ev_q.push_back(EvError);
        send(8'hF1);
        probe("bad_csum", 5'h05, 8'h05, 2'd3, 1'b0);
        start();
        probe("restart_from_error", 5'h05, 8'h05, 2'd1, 1'b1);

        // Partial stream 0x80.. with gaps, then start collides with a valid byte.
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h80 + i));
            tick(i % 3);
        end
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'hEE;
        bus.load_start = 1'b1;
        probe("start_blocks_ready", 5'h0A, 8'h0A, 2'd1, 1'b0);
        tick(1);
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        probe("colliding_byte_dropped", 5'h0A, 8'h0A, 2'd1, 1'b1);
        probe("stale_partial", 5'h00, 8'h80, 2'd1, 1'b1);

        // Full load of i*5+1 with gaps; sum = 2512 mod 256 = 0xD0.
        for (int i = 0; i < 32; i++) begin
            send(8'(i * 5 + 1));
            if (i % 4 == 3) tick(2);
        end
        ev_q.push_back(EvDone);
        send(8'hD0);
        probe("reload_idx00", 5'h00, 8'h01, 2'd2, 1'b0);
        probe("reload_idx0A", 5'h0A, 8'h33, 2'd2, 1'b0);
        probe("reload_idx1F", 5'h1F, 8'h9C, 2'd2, 1'b0);

        // Timeout (TIMEOUT=8): acceptance on the 8th stalled cycle wins,
        // 8 stalled cycles without acceptance end in ERROR.
        start();
        for (int i = 0; i < 5; i++) send(8'(8'h11 + i));
        tick(7);
        probe("stall_7", 5'h05, 8'h1A, 2'd1, 1'b1);
        send(8'h16);
        probe("accept_beats_timeout", 5'h05, 8'h16, 2'd1, 1'b1);
        tick(7);
        probe("stall_7b", 5'h06, 8'h1F, 2'd1, 1'b1);
        ev_q.push_back(EvError);
        tick(1);
        probe("timeout_error", 5'h04, 8'h15, 2'd3, 1'b0);

        // Async reset between edges mid-load wipes memory and returns to IDLE.
        start();
        probe("reload_from_timeout", 5'h00, 8'h11, 2'd1, 1'b1);
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'hA4;
        #2 reset = 1'b1;
        probe("async_reset", 5'h00, 8'h00, 2'd0, 1'b0);
        for (int i = 0; i < 32; i++) probe("async_reset_mem", 5'(i), 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        bus.load_valid = 1'b0;
        tick(1);
        probe("idle_after_async_reset", 5'h02, 8'h00, 2'd0, 1'b0);

        tick(2);
        vectors++;
        if (ev_q.size() != 0 || probe_q.size() != 0) begin
            miscompares++;
            $display("FAIL queues_drained: got events=%0d probes=%0d left, want 0 and 0",
                     ev_q.size(), probe_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
